// File: rtl/serial_sub16_if.sv
// Handshake and operand/result bundle for the nibble-serial subtractor.
// The master issues start with operands; the slave returns busy/done, Z and flags.
interface serial_sub16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Z;
    logic             carry;
    logic             sign;
    logic             overflow;
    logic             parity;
    logic             zero;

    modport master (
        output start, X, Y,
        input  busy, done, Z, carry, sign, overflow, parity, zero
    );

    modport slave (
        input  start, X, Y,
        output busy, done, Z, carry, sign, overflow, parity, zero
    );
endinterface

// File: rtl/serial_sub16.sv
// Slice-serial Z = X - Y (X + ~Y + 1) with adder-style status flags.
// Latency WIDTH/SLICE cycles from the accepting edge to the one-cycle done pulse.
// No backpressure: start is ignored while busy and accepted again in the done cycle.
module serial_sub16 #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic              clk,
    input  logic              rst,
    serial_sub16_if.slave     bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNTW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int MSB    = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNTW-1:0]   r_cnt;
    logic              r_cflop;
    logic [WIDTH-1:0]  r_x;
    logic [WIDTH-1:0]  r_y;
    logic [WIDTH-1:0]  r_z;
    logic              r_carry;
    logic              r_sign;
    logic              r_overflow;
    logic              r_parity;
    logic              r_zero;

    logic              w_accept;
    logic              w_slice_en;
    logic              w_last;
    logic [SLICE-1:0]  w_xs;
    logic [SLICE-1:0]  w_ys;
    logic [SLICE:0]    w_sum;
    logic [WIDTH-1:0]  w_z_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_slice_en  = 1'b0;
        w_last      = (r_cnt == CNTW'(NSLICE - 1));
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_slice_en = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // A start here chains straight into the next run with no idle gap.
                w_state_nxt = S_IDLE;
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_xs    = r_x[r_cnt*SLICE +: SLICE];
        w_ys    = r_y[r_cnt*SLICE +: SLICE];
        w_sum   = {1'b0, w_xs} + {1'b0, ~w_ys} + {{SLICE{1'b0}}, r_cflop};
        w_z_nxt = r_z;
        w_z_nxt[r_cnt*SLICE +: SLICE] = w_sum[SLICE-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_cflop    <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_z        <= '0;
            r_carry    <= 1'b0;
            r_sign     <= 1'b0;
            r_overflow <= 1'b0;
            r_parity   <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_accept) begin
            r_x     <= bus.X;
            r_y     <= bus.Y;
            r_cflop <= 1'b1;
            r_cnt   <= '0;
        end else if (w_slice_en) begin
            r_z     <= w_z_nxt;
            r_cflop <= w_sum[SLICE];
            r_cnt   <= r_cnt + 1'b1;
            // Flags land with the final slice so they are valid throughout the done cycle.
            if (w_last) begin
                r_carry    <= w_sum[SLICE];
                r_sign     <= w_z_nxt[MSB];
                r_overflow <= (r_x[MSB] & ~r_y[MSB] & ~w_z_nxt[MSB]) |
                              (~r_x[MSB] & r_y[MSB] & w_z_nxt[MSB]);
                r_parity   <= ~^w_z_nxt;
                r_zero     <= ~|w_z_nxt;
            end
        end
    end

    assign bus.busy     = (r_state == S_RUN);
    assign bus.done     = (r_state == S_DONE);
    assign bus.Z        = r_z;
    assign bus.carry    = r_carry;
    assign bus.sign     = r_sign;
    assign bus.overflow = r_overflow;
    assign bus.parity   = r_parity;
    assign bus.zero     = r_zero;
endmodule

// File: tb/tb_serial_sub16.sv
// Scoreboard bench for serial_sub16: expected results queued at issue, popped on done.
module tb_serial_sub16;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_sub16_if #(.WIDTH(16)) bus ();
    serial_sub16 #(.WIDTH(16), .SLICE(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [15:0] z;
        logic        c;
        logic        s;
        logic        o;
        logic        p;
        logic        zr;
    } res_t;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic res_t model(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] t;
        res_t        r;
        t    = {1'b0, x} + {1'b0, ~y} + 17'd1;
        r.z  = t[15:0];
        r.c  = t[16];
        r.s  = t[15];
        r.o  = (x[15] & ~y[15] & ~t[15]) | (~x[15] & y[15] & t[15]);
        r.p  = ~^t[15:0];
        r.zr = (t[15:0] == 16'h0000);
        return r;
    endfunction

    function automatic res_t observed();
        res_t r;
        r = {bus.Z, bus.carry, bus.sign, bus.overflow, bus.parity, bus.zero};
        return r;
    endfunction

    function automatic res_t mk(input logic [15:0] z, input logic c, input logic s,
                                input logic o, input logic p, input logic zr);
        res_t r;
        r = {z, c, s, o, p, zr};
        return r;
    endfunction

    // Called at posedge+1; returns at the accepting edge +1.
    task automatic issue(input logic [15:0] x, input logic [15:0] y,
                         input bit push, input res_t e);
        bus.start = 1'b1;
        bus.X     = x;
        bus.Y     = y;
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.X     = 16'($urandom);
        bus.Y     = 16'($urandom);
    endtask

    task automatic collect(output int lat, output int busy_cyc, output bit to, output res_t got);
        lat = 0; busy_cyc = 0; to = 1'b1; got = '0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy) busy_cyc++;
            @(posedge clk); #1;
            lat++;
            if (bus.done) begin
                to  = 1'b0;
                got = observed();
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.X = 16'h0; bus.Y = 16'h0;
        repeat (2) @(posedge clk); #1;
        n_checks++;
        if ({bus.busy, bus.done, observed()} !== 23'h0)
            $display("FAIL reset_state: got busy=%b done=%b res=%h, expected all 0",
                     bus.busy, bus.done, observed());
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        int lat, bc; bit to; res_t got, e;
        issue(16'h0005, 16'h0003, 1'b1, mk(16'h0002, 1, 0, 0, 0, 0));
        collect(lat, bc, to, got);
        n_checks++;
        if (to) $display("FAIL lat_timeout: no done within 20 cycles");
        else n_pass++;
        n_checks++;
        if (lat !== 4) $display("FAIL latency: got %0d cycles, expected 4", lat);
        else n_pass++;
        n_checks++;
        if (bc !== 4) $display("FAIL busy_cycles: got %0d, expected 4", bc);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL busy_in_done: got %b, expected 0", bus.busy);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) $display("FAIL sub_5_3: got %h, expected %h", got, e);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (bus.done !== 1'b0) $display("FAIL done_pulse_width: got %b, expected 0", bus.done);
        else n_pass++;
    endtask

    task automatic test_flags();
        logic [15:0] xs [4] = '{16'h0003, 16'h8000, 16'h7FFF, 16'h1234};
        logic [15:0] ys [4] = '{16'h0005, 16'h0001, 16'hFFFF, 16'h1234};
        res_t        es [4];
        int lat, bc; bit to; res_t got, e;
        es[0] = mk(16'hFFFE, 0, 1, 0, 0, 0);
        es[1] = mk(16'h7FFF, 1, 0, 1, 0, 0);
        es[2] = mk(16'h8000, 0, 1, 1, 0, 0);
        es[3] = mk(16'h0000, 1, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            issue(xs[i], ys[i], 1'b1, es[i]);
            collect(lat, bc, to, got);
            e = exp_q.pop_front();
            n_checks++;
            if (to || got !== e)
                $display("FAIL flags_%0d: got %h (timeout=%b), expected %h", i, got, to, e);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_start();
        int lat, bc, extra; bit to; res_t got, e;
        issue(16'h00F0, 16'h000F, 1'b1, mk(16'h00E1, 1, 0, 0, 1, 0));
        @(posedge clk); #1;
        bus.start = 1'b1; bus.X = 16'hAAAA; bus.Y = 16'h5555;
        @(posedge clk); #1;
        bus.start = 1'b0;
        collect(lat, bc, to, got);
        e = exp_q.pop_front();
        n_checks++;
        if (to || got !== e)
            $display("FAIL ignore_start_result: got %h (timeout=%b), expected %h", got, to, e);
        else n_pass++;
        n_checks++;
        if (lat !== 2) $display("FAIL ignore_start_timing: got %0d remaining cycles, expected 2", lat);
        else n_pass++;
        extra = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) extra++;
        end
        n_checks++;
        if (extra !== 0) $display("FAIL ignore_start_extra_op: got %0d active cycles, expected 0", extra);
        else n_pass++;
    endtask

    task automatic test_abort();
        int lat, bc, seen; bit to; res_t got, e;
        issue(16'h1234, 16'h0001, 1'b0, '0);
        @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL abort_precond_busy: got %b, expected 1", bus.busy);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, observed()} !== 23'h0)
            $display("FAIL abort_outputs: got busy=%b done=%b res=%h, expected all 0",
                     bus.busy, bus.done, observed());
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL abort_no_done: got %0d active cycles, expected 0", seen);
        else n_pass++;
        issue(16'h0005, 16'h0003, 1'b1, mk(16'h0002, 1, 0, 0, 0, 0));
        collect(lat, bc, to, got);
        e = exp_q.pop_front();
        n_checks++;
        if (to || got !== e || lat !== 4)
            $display("FAIL abort_recover: got %h lat=%0d (timeout=%b), expected %h lat=4", got, lat, to, e);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat, bc; bit to; res_t got, ea, eb;
        issue(16'h0010, 16'h0001, 1'b1, mk(16'h000F, 1, 0, 0, 1, 0));
        collect(lat, bc, to, got);
        ea = exp_q.pop_front();
        n_checks++;
        if (to || got !== ea) $display("FAIL b2b_op_a: got %h (timeout=%b), expected %h", got, to, ea);
        else n_pass++;
        issue(16'h0000, 16'h0001, 1'b1, mk(16'hFFFF, 0, 1, 0, 1, 0));
        n_checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0)
            $display("FAIL b2b_no_gap: got busy=%b done=%b, expected busy=1 done=0", bus.busy, bus.done);
        else n_pass++;
        n_checks++;
        if (observed() !== ea) $display("FAIL b2b_hold: got %h, expected %h", observed(), ea);
        else n_pass++;
        collect(lat, bc, to, got);
        eb = exp_q.pop_front();
        n_checks++;
        if (to || got !== eb) $display("FAIL b2b_op_b: got %h (timeout=%b), expected %h", got, to, eb);
        else n_pass++;
        n_checks++;
        if (lat !== 4) $display("FAIL b2b_spacing: got %0d, expected 4 (5 cycles done-to-done)", lat);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat, bc; bit to; res_t got, e;
        logic [15:0] x, y;
        for (int i = 0; i < 8; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            issue(x, y, 1'b1, model(x, y));
            collect(lat, bc, to, got);
            e = exp_q.pop_front();
            n_checks++;
            if (to || got !== e)
                $display("FAIL random_%0d: %h-%h got %h (timeout=%b), expected %h", i, x, y, got, to, e);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_flags();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
